pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives the enable and flush inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers.
- Handles three events: load-use hazards, taken branches resolved in EX, and multi-cycle data-memory accesses, which freeze the whole pipeline for a fixed number of cycles.

Parameters:
- REG_ADDR_W, 5: register address width.
- MEM_WAIT, 2: freeze cycles per data-memory access; 0 disables freezing.
- CNT_W, 4: wait-counter width; requires MEM_WAIT < 2**CNT_W.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_rs  in  REG_ADDR_W  source register 1 of the instruction in ID.
- id_rt  in  REG_ADDR_W  source register 2 of the instruction in ID.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  REG_ADDR_W  destination register of the instruction in EX.
- branch_taken  in  1  branch resolved taken in EX this cycle.
- mem_access  in  1  instruction in MEM is a load or store.
- pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable  out  1 each  register enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  register flushes.
- busy  out  1  high while the memory freeze is active.

Behaviour:
- State: FSM {RUN, MWAIT}, wait counter cnt[CNT_W-1:0], flag mem_done.
- Reset (async, while reset=1): state=RUN, cnt=0, mem_done=0; all enables=0, all flushes=0, busy=0.
- Output decode: combinational from state and inputs, in priority order freeze > branch > load-use > normal.
- Freeze condition: (state==MWAIT) or (state==RUN and mem_access and !mem_done and MEM_WAIT>0).
  - Outputs: all enables=0, all flushes=0, busy=1.
  - branch_taken and the load-use condition are ignored.
- Branch (RUN, no freeze, branch_taken=1):
  - All enables=1; ifid_flush=1, idex_flush=1; exmem_flush=0, memwb_flush=0.
  - Wins over a simultaneous load-use hazard.
- Load-use (RUN, no freeze, no branch):
  - Condition: ex_mem_read and ex_rd!=0 and (ex_rd==id_rs or ex_rd==id_rt).
  - pc_enable=0, ifid_enable=0, idex_flush=1 (bubble); idex_enable, exmem_enable and memwb_enable=1; other flushes=0.
  - Exactly one stall cycle: the hazard clears once the load moves to MEM.
- Normal: all enables=1, all flushes=0, busy=0.
- Transitions:
  - RUN -> MWAIT when the freeze condition holds in RUN and MEM_WAIT>1; cnt <= MEM_WAIT-2.
  - RUN with MEM_WAIT==1 and the freeze condition: stay RUN, mem_done<=1 (single freeze cycle).
  - MWAIT: if cnt==0 -> RUN and mem_done<=1; else cnt<=cnt-1.
  - mem_done <= 0 on any RUN cycle without freeze, i.e. when the pipeline advances.
  - Net effect: each memory instruction freezes the pipeline for exactly MEM_WAIT consecutive cycles, then advances with no re-trigger.
- Back-to-back memory instructions: the second one freezes again after the single advancing cycle.
- MEM_WAIT==0: mem_access is ignored; busy stays 0.
- Reset mid-freeze: returns to RUN immediately; the freeze is abandoned and mem_done is cleared.
- Contract with the pipe registers: they give flush priority over enable, so any enable value paired with flush=1 is don't-care for them but is still driven exactly as stated above.

Optional Feature:
- HAZARD_PERF_EN defined:
  - Adds output stall_cycles[15:0] and output flush_events[15:0], both reset to 0.
  - stall_cycles +1 on every cycle with pc_enable=0 outside reset.
  - flush_events +1 on every branch-flush cycle.
  - Both counters saturate at 16'hFFFF.
- HAZARD_PERF_EN undefined: neither port exists and no counter logic is built.

Test Plan:
- Reset: assert reset mid-cycle -> outputs go to all enables 0, all flushes 0, busy 0 immediately; first cycle after release with idle inputs -> all enables 1.
- Load-use: ex_mem_read=1, ex_rd=5, id_rt=5 -> one cycle with pc_enable=0, ifid_enable=0, idex_flush=1; ex_rd=0 with id_rs=0 -> no stall.
- Branch vs load-use: branch_taken=1 together with a load-use hazard -> ifid_flush=1, idex_flush=1, pc_enable=1; no stall cycle.
- Memory freeze, MEM_WAIT=2: hold mem_access=1 -> exactly 2 cycles with all enables 0 and busy 1, then 1 cycle all enables 1, then the next held access freezes 2 more cycles.
- Reset during MWAIT: state=RUN, busy 0; with mem_access=1 still high after release -> a fresh full 2-cycle freeze.
- HAZARD_PERF_EN: 3 load-use stalls plus 2 branches -> stall_cycles=3, flush_events=2; force 70000 stall cycles -> stall_cycles=16'hFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush controller for a 5-stage pipeline. It drives the enable
// and flush inputs of the PC register and of the IF/ID, ID/EX, EX/MEM and
// MEM/WB pipe registers.
//
// Three events are handled, highest priority first:
//   memory freeze : a multi-cycle data-memory access freezes the whole
//                   pipeline for MEM_WAIT consecutive cycles
//   branch        : a taken branch resolved in EX squashes IF/ID and ID/EX
//   load-use      : a load in EX feeding the instruction in ID stalls PC and
//                   IF/ID for one cycle and inserts a bubble into ID/EX
//
// Parameters:
//   REG_ADDR_W : register address width
//   MEM_WAIT   : freeze cycles per memory access (0 disables freezing)
//   CNT_W      : wait counter width, MEM_WAIT must be below 2**CNT_W
//
// Ports:
//   clk, reset                  rising-edge clock, async active-high reset
//   id_rs, id_rt                source registers of the instruction in ID
//   ex_mem_read, ex_rd          load flag and destination of the EX instruction
//   branch_taken                branch resolved taken in EX this cycle
//   mem_access                  instruction in MEM is a load or store
//   *_enable                    PC and pipe register enables
//   *_flush                     pipe register flushes
//   busy                        high while the memory freeze is active
//   stall_cycles, flush_events  performance counters (HAZARD_PERF_EN only)
//
// Optional feature macro: HAZARD_PERF_EN adds two saturating 16-bit counters.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MEM_WAIT   = 2,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  branch_taken,
    input  logic                  mem_access,
    output logic                  pc_enable,
    output logic                  ifid_enable,
    output logic                  idex_enable,
    output logic                  exmem_enable,
    output logic                  memwb_enable,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic                  memwb_flush,
`ifdef HAZARD_PERF_EN
    output logic [15:0]           stall_cycles,
    output logic [15:0]           flush_events,
`endif
    output logic                  busy
);

    typedef enum logic {
        RUN   = 1'b0,
        MWAIT = 1'b1
    } stateT;

    localparam bit             WAIT_ON    = (MEM_WAIT > 0);
    localparam bit             WAIT_MULTI = (MEM_WAIT > 1);
    // The first freeze cycle is spent in RUN and the last one ends with the
    // counter at zero, hence the load value of MEM_WAIT-2.
    localparam logic [CNT_W-1:0] CNT_LOAD = WAIT_MULTI ? CNT_W'(MEM_WAIT - 2) : '0;

    stateT            r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_memDone;

    logic w_freeze;
    logic w_loadUse;
    logic w_branchFlush;

    // mem_done blocks a re-trigger by the same memory instruction, which is
    // still sitting in MEM on the cycle right after its freeze completes.
    assign w_freeze = (r_state == MWAIT) ||
                      (WAIT_ON && mem_access && !r_memDone);

    assign w_loadUse = ex_mem_read && (ex_rd != '0) &&
                       ((ex_rd == id_rs) || (ex_rd == id_rt));

    assign w_branchFlush = !reset && !w_freeze && branch_taken;

    // Output decode: freeze > branch > load-use > normal; everything is held
    // low while reset is asserted.
    always_comb begin
        pc_enable    = 1'b0;
        ifid_enable  = 1'b0;
        idex_enable  = 1'b0;
        exmem_enable = 1'b0;
        memwb_enable = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        memwb_flush  = 1'b0;
        busy         = 1'b0;
        if (!reset) begin
            if (w_freeze) begin
                busy = 1'b1;
            end else if (branch_taken) begin
                pc_enable    = 1'b1;
                ifid_enable  = 1'b1;
                idex_enable  = 1'b1;
                exmem_enable = 1'b1;
                memwb_enable = 1'b1;
                ifid_flush   = 1'b1;
                idex_flush   = 1'b1;
            end else if (w_loadUse) begin
                idex_enable  = 1'b1;
                exmem_enable = 1'b1;
                memwb_enable = 1'b1;
                idex_flush   = 1'b1;
            end else begin
                pc_enable    = 1'b1;
                ifid_enable  = 1'b1;
                idex_enable  = 1'b1;
                exmem_enable = 1'b1;
                memwb_enable = 1'b1;
            end
        end
    end

    // Freeze sequencer. With MEM_WAIT==1 the single freeze cycle is handled
    // entirely in RUN by setting mem_done; longer waits count down in MWAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_memDone <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_freeze) begin
                        if (WAIT_MULTI) begin
                            r_state <= MWAIT;
                            r_cnt   <= CNT_LOAD;
                        end else begin
                            r_memDone <= 1'b1;
                        end
                    end else begin
                        r_memDone <= 1'b0;
                    end
                end
                MWAIT: begin
                    if (r_cnt == '0) begin
                        r_state   <= RUN;
                        r_memDone <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [15:0] r_stallCycles;
    logic [15:0] r_flushEvents;

    // Saturating event counters; a stall is any cycle where the PC holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stallCycles <= '0;
            r_flushEvents <= '0;
        end else begin
            if (!pc_enable && (r_stallCycles != 16'hFFFF)) begin
                r_stallCycles <= r_stallCycles + 16'd1;
            end
            if (w_branchFlush && (r_flushEvents != 16'hFFFF)) begin
                r_flushEvents <= r_flushEvents + 16'd1;
            end
        end
    end

    assign stall_cycles = r_stallCycles;
    assign flush_events = r_flushEvents;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Self-checking bench for pipe_hazard_ctrl with MEM_WAIT=2. A behavioural
// model tracks "freeze cycles still owed" for the memory instruction in MEM
// and decides every cycle which of the four pipeline actions applies; a
// compare process checks the DUT against it on every falling edge. Directed
// steps add literal expectations that pin the model itself.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int REG_ADDR_W = 5;
    localparam int MEM_WAIT   = 2;

    // Output bit order: pc ifid idex exmem memwb | ifidF idexF exmemF memwbF | busy
    localparam logic [9:0] OUT_RESET  = 10'b00000_0000_0;
    localparam logic [9:0] OUT_NORMAL = 10'b11111_0000_0;
    localparam logic [9:0] OUT_BRANCH = 10'b11111_1100_0;
    localparam logic [9:0] OUT_STALL  = 10'b00111_0100_0;
    localparam logic [9:0] OUT_FREEZE = 10'b00000_0000_1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  branch_taken;
    logic                  mem_access;
    logic pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic busy;
`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_events;
`endif

    int cmpCount = 0;
    int errCount = 0;

    // Model state: freeze cycles still owed, and whether the memory
    // instruction currently in MEM has already been served.
    int mOwed   = 0;
    bit mServed = 1'b0;

    logic [9:0] actualOut;

    pipe_hazard_ctrl #(
        .REG_ADDR_W(REG_ADDR_W),
        .MEM_WAIT  (MEM_WAIT),
        .CNT_W     (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .branch_taken(branch_taken),
        .mem_access  (mem_access),
        .pc_enable   (pc_enable),
        .ifid_enable (ifid_enable),
        .idex_enable (idex_enable),
        .exmem_enable(exmem_enable),
        .memwb_enable(memwb_enable),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .exmem_flush (exmem_flush),
        .memwb_flush (memwb_flush),
`ifdef HAZARD_PERF_EN
        .stall_cycles(stall_cycles),
        .flush_events(flush_events),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    assign actualOut = {pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable,
                        ifid_flush, idex_flush, exmem_flush, memwb_flush, busy};

    // True when the pipeline must be frozen this cycle.
    function automatic bit modelFreeze();
        return (mOwed > 0) || (MEM_WAIT > 0 && mem_access && !mServed);
    endfunction

    // Required outputs from the current model state and inputs.
    function automatic logic [9:0] modelOut();
        bit hazard;
        hazard = ex_mem_read && (ex_rd != 0) && (ex_rd == id_rs || ex_rd == id_rt);
        if (reset)             return OUT_RESET;
        else if (modelFreeze()) return OUT_FREEZE;
        else if (branch_taken) return OUT_BRANCH;
        else if (hazard)       return OUT_STALL;
        else                   return OUT_NORMAL;
    endfunction

    // Model advance: a new memory instruction owes MEM_WAIT freeze cycles
    // (one spent now); it is marked served once they are paid and forgotten
    // when the pipeline advances.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mOwed   <= 0;
            mServed <= 1'b0;
        end else if (mOwed > 0) begin
            mOwed <= mOwed - 1;
            if (mOwed == 1) mServed <= 1'b1;
        end else if (modelFreeze()) begin
            mOwed   <= MEM_WAIT - 1;
            mServed <= (MEM_WAIT == 1);
        end else begin
            mServed <= 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [9:0] expected);
        cmpCount++;
        if (actualOut !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actualOut, expected, $time);
        end
    endtask

    task automatic checkCount(input string name, input logic [15:0] actual, input logic [15:0] expected);
        cmpCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then settle to
    // the falling edge where outputs are sampled.
    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                                 input logic [4:0] rd, input logic br, input logic ma);
        @(posedge clk);
        #1;
        id_rs        = rs;
        id_rt        = rt;
        ex_mem_read  = mr;
        ex_rd        = rd;
        branch_taken = br;
        mem_access   = ma;
        @(negedge clk);
    endtask

    // Compare process: DUT against the model on every falling edge.
    always @(negedge clk) begin
        checkOutput("model", modelOut());
    end

    typedef struct {
        logic [4:0] rs, rt, rd;
        logic       mr, br, ma;
    } vecT;

    vecT table1[12];

    initial begin
        reset = 1'b1;
        id_rs = '0; id_rt = '0; ex_mem_read = 1'b0; ex_rd = '0;
        branch_taken = 1'b0; mem_access = 1'b0;
        #1;
        checkOutput("resetHold", OUT_RESET);

        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("idleAfterReset", OUT_NORMAL);

        applyStimulus(0, 5, 1, 5, 0, 0);  checkOutput("loadUseRt", OUT_STALL);
        applyStimulus(0, 5, 0, 5, 0, 0);  checkOutput("loadMovedOn", OUT_NORMAL);
        applyStimulus(0, 0, 1, 0, 0, 0);  checkOutput("rdZeroNoStall", OUT_NORMAL);
        applyStimulus(7, 3, 1, 7, 0, 0);  checkOutput("loadUseRs", OUT_STALL);
        applyStimulus(7, 3, 1, 7, 1, 0);  checkOutput("branchOverLoadUse", OUT_BRANCH);
        applyStimulus(7, 3, 0, 7, 0, 0);  checkOutput("afterBranch", OUT_NORMAL);

        applyStimulus(0, 0, 0, 0, 0, 1);  checkOutput("freeze1", OUT_FREEZE);
        applyStimulus(7, 7, 1, 7, 1, 1);  checkOutput("freeze2IgnoresHazards", OUT_FREEZE);
        applyStimulus(0, 0, 0, 0, 0, 1);  checkOutput("advanceAfterFreeze", OUT_NORMAL);
        applyStimulus(0, 0, 0, 0, 0, 1);  checkOutput("refreeze1", OUT_FREEZE);
        applyStimulus(0, 0, 0, 0, 0, 1);  checkOutput("refreeze2", OUT_FREEZE);
        applyStimulus(0, 0, 0, 0, 0, 0);  checkOutput("idleAfterRefreeze", OUT_NORMAL);

        // Reset while the freeze is in its counting phase.
        applyStimulus(0, 0, 0, 0, 0, 1);  checkOutput("preResetFreeze", OUT_FREEZE);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("resetMidFreeze", OUT_RESET);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("freshFreeze1", OUT_FREEZE);
        applyStimulus(0, 0, 0, 0, 0, 1);  checkOutput("freshFreeze2", OUT_FREEZE);
        applyStimulus(0, 0, 0, 0, 0, 1);  checkOutput("freshAdvance", OUT_NORMAL);
        applyStimulus(0, 0, 0, 0, 0, 0);  checkOutput("freshIdle", OUT_NORMAL);

        // Mixed vectors checked by the model alone.
        table1[0]  = '{rs: 5'd1,  rt: 5'd2,  rd: 5'd2,  mr: 1'b1, br: 1'b0, ma: 1'b0};
        table1[1]  = '{rs: 5'd1,  rt: 5'd2,  rd: 5'd2,  mr: 1'b1, br: 1'b0, ma: 1'b1};
        table1[2]  = '{rs: 5'd9,  rt: 5'd9,  rd: 5'd9,  mr: 1'b1, br: 1'b1, ma: 1'b1};
        table1[3]  = '{rs: 5'd9,  rt: 5'd4,  rd: 5'd9,  mr: 1'b1, br: 1'b0, ma: 1'b1};
        table1[4]  = '{rs: 5'd3,  rt: 5'd4,  rd: 5'd5,  mr: 1'b1, br: 1'b1, ma: 1'b0};
        table1[5]  = '{rs: 5'd31, rt: 5'd0,  rd: 5'd31, mr: 1'b0, br: 1'b0, ma: 1'b0};
        table1[6]  = '{rs: 5'd31, rt: 5'd0,  rd: 5'd31, mr: 1'b1, br: 1'b0, ma: 1'b0};
        table1[7]  = '{rs: 5'd0,  rt: 5'd0,  rd: 5'd0,  mr: 1'b0, br: 1'b0, ma: 1'b1};
        table1[8]  = '{rs: 5'd0,  rt: 5'd0,  rd: 5'd0,  mr: 1'b0, br: 1'b1, ma: 1'b0};
        table1[9]  = '{rs: 5'd6,  rt: 5'd6,  rd: 5'd6,  mr: 1'b1, br: 1'b0, ma: 1'b1};
        table1[10] = '{rs: 5'd6,  rt: 5'd6,  rd: 5'd6,  mr: 1'b1, br: 1'b0, ma: 1'b1};
        table1[11] = '{rs: 5'd6,  rt: 5'd6,  rd: 5'd6,  mr: 1'b1, br: 1'b0, ma: 1'b1};
        for (int i = 0; i < 12; i++) begin
            applyStimulus(table1[i].rs, table1[i].rt, table1[i].mr,
                          table1[i].rd, table1[i].br, table1[i].ma);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);

`ifdef HAZARD_PERF_EN
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkCount("stallAfterReset", stall_cycles, 16'd0);
        applyStimulus(2, 0, 1, 2, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 2, 1, 2, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(2, 2, 1, 2, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkCount("stallCycles3", stall_cycles, 16'd3);
        checkCount("flushEvents2", flush_events, 16'd2);
        applyStimulus(2, 0, 1, 2, 0, 0);
        repeat (70000) @(posedge clk);
        @(negedge clk);
        checkCount("stallSaturate", stall_cycles, 16'hFFFF);
        checkCount("flushHeld", flush_events, 16'd2);
        applyStimulus(0, 0, 0, 0, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
